// File: rtl/ex_stage_pipe.sv
// ============================================================================
// ex_stage_pipe
// ----------------------------------------------------------------------------
// Execute stage of the pipelined core. It sits between the ID/EX register
// (its inputs) and the memory stage (its registered EX/MEM outputs).
//
// Contents:
//   - Operand forwarding from EX/MEM (this stage's own outputs) and from MEM/WB.
//   - Single-cycle ALU: AND, OR, ADD, XOR, SUB, SLL, SRL, SLT.
//   - Branch-target adder: pc + (imm << 1).
//   - Iterative shift-add multiplier. It produces one partial-product step per
//     cycle and stalls upstream through a two-state FSM (IDLE / MUL).
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid          ID/EX holds a valid instruction
//   read_data1/2      register-file values for rs1/rs2
//   pc, immediate     instruction PC, sign-extended immediate (low WIDTH used)
//   rs1, rs2, rd      source and destination register indices
//   alu_control       operation code
//   ctrl              control bundle: [0]=ALUSrc [1]=Branch [2]=RegWrite
//   flush             kill the current or in-flight instruction
//   wb_rd, wb_regwrite, wb_data   MEM/WB writeback, used for forwarding
//   stall_out         upstream must hold ID/EX (combinational)
//   out_valid, alu_result, zero, branch_target, branch_taken,
//   store_data, rd_out, ctrl_out  registered EX/MEM outputs
// ============================================================================
module ex_stage_pipe #(
    parameter int WIDTH  = 32,
    parameter int IMM_W  = 64,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  read_data1,
    input  logic [WIDTH-1:0]  read_data2,
    input  logic [WIDTH-1:0]  pc,
    input  logic [IMM_W-1:0]  immediate,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [4:0]        rd,
    input  logic [3:0]        alu_control,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              flush,
    input  logic [4:0]        wb_rd,
    input  logic              wb_regwrite,
    input  logic [WIDTH-1:0]  wb_data,
    output logic              stall_out,
    output logic              out_valid,
    output logic [WIDTH-1:0]  alu_result,
    output logic              zero,
    output logic [WIDTH-1:0]  branch_target,
    output logic              branch_taken,
    output logic [WIDTH-1:0]  store_data,
    output logic [4:0]        rd_out,
    output logic [CTRL_W-1:0] ctrl_out
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    // FSM and multiplier state
    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   acc_q;      // running partial product
    logic [WIDTH-1:0]   mcand_q;    // multiplicand, shifted left each step
    logic [WIDTH-1:0]   mplier_q;   // multiplier, shifted right each step
    logic [WIDTH-1:0]   mul_bt_q;   // side fields captured at accept
    logic [WIDTH-1:0]   mul_sd_q;
    logic [4:0]         mul_rd_q;
    logic [CTRL_W-1:0]  mul_ctrl_q;

    // EX/MEM register
    logic               out_valid_q;
    logic [WIDTH-1:0]   alu_result_q;
    logic               zero_q;
    logic [WIDTH-1:0]   branch_target_q;
    logic               branch_taken_q;
    logic [WIDTH-1:0]   store_data_q;
    logic [4:0]         rd_out_q;
    logic [CTRL_W-1:0]  ctrl_out_q;

    // Combinational datapath
    logic [WIDTH-1:0]   fwd_a;
    logic [WIDTH-1:0]   fwd_b;
    logic [WIDTH-1:0]   imm_w;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   bt_new;
    logic [WIDTH-1:0]   mul_sum;
    logic               is_mul;
    logic               accept_mul;
    logic               issue_alu;
    logic               mul_done;

    // EX/MEM load selection
    logic               load_d;
    logic [WIDTH-1:0]   res_d;
    logic [WIDTH-1:0]   bt_d;
    logic [WIDTH-1:0]   sd_d;
    logic [4:0]         rd_d;
    logic [CTRL_W-1:0]  ctrl_d;

    // Only the low WIDTH bits of the immediate carry information.
    if (IMM_W > WIDTH) begin : g_imm_hi
        logic unused_imm_hi;
        assign unused_imm_hi = ^immediate[IMM_W-1:WIDTH];
    end

    assign imm_w  = immediate[WIDTH-1:0];
    assign bt_new = pc + (imm_w << 1);

    // Forwarding. EX/MEM wins over MEM/WB. Index 0 never forwards. A bubble in
    // EX/MEM has out_valid low, so it can never be a forwarding source.
    always_comb begin
        // NOTE: give every always_comb output a default first; a path that
        // leaves one unassigned would infer a latch.
        fwd_a = read_data1;
        fwd_b = read_data2;
        if (rs1 != 5'd0) begin
            if (out_valid_q && ctrl_out_q[2] && rd_out_q == rs1) begin
                fwd_a = alu_result_q;
            end else if (wb_regwrite && wb_rd == rs1) begin
                fwd_a = wb_data;
            end
        end
        if (rs2 != 5'd0) begin
            if (out_valid_q && ctrl_out_q[2] && rd_out_q == rs2) begin
                fwd_b = alu_result_q;
            end else if (wb_regwrite && wb_rd == rs2) begin
                fwd_b = wb_data;
            end
        end
    end

    assign op_b = ctrl[0] ? imm_w : fwd_b;

    always_comb begin
        alu_res = '0;
        unique case (alu_control)
            OP_AND:  alu_res = fwd_a & op_b;
            OP_OR:   alu_res = fwd_a | op_b;
            OP_ADD:  alu_res = fwd_a + op_b;
            OP_XOR:  alu_res = fwd_a ^ op_b;
            OP_SUB:  alu_res = fwd_a - op_b;
            OP_SLL:  alu_res = fwd_a << op_b[SH_W-1:0];
            OP_SRL:  alu_res = fwd_a >> op_b[SH_W-1:0];
            OP_SLT:  alu_res[0] = $signed(fwd_a) < $signed(op_b);
            default: alu_res = '0;   // MUL goes through the iterative path
        endcase
    end

    // One shift-add step. On the last step this sum is the final product and
    // goes straight into EX/MEM.
    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign is_mul     = (alu_control == OP_MUL);
    assign accept_mul = (state_q == S_IDLE) && in_valid && !flush && is_mul;
    assign issue_alu  = (state_q == S_IDLE) && in_valid && !flush && !is_mul;
    assign mul_done   = (state_q == S_MUL) && !flush && (count_q == CNT_LAST);

    // A flush releases the stall immediately, even in the middle of a multiply.
    assign stall_out = accept_mul ||
                       ((state_q == S_MUL) && !flush && (count_q != CNT_LAST));

    always_comb begin
        load_d = issue_alu || mul_done;
        res_d  = alu_res;
        bt_d   = bt_new;
        sd_d   = fwd_b;
        rd_d   = rd;
        ctrl_d = ctrl;
        if (state_q == S_MUL) begin
            res_d  = mul_sum;
            bt_d   = mul_bt_q;
            sd_d   = mul_sd_q;
            rd_d   = mul_rd_q;
            ctrl_d = mul_ctrl_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q         <= S_IDLE;
            count_q         <= '0;
            acc_q           <= '0;
            mcand_q         <= '0;
            mplier_q        <= '0;
            mul_bt_q        <= '0;
            mul_sd_q        <= '0;
            mul_rd_q        <= '0;
            mul_ctrl_q      <= '0;
            out_valid_q     <= 1'b0;
            alu_result_q    <= '0;
            zero_q          <= 1'b0;
            branch_target_q <= '0;
            branch_taken_q  <= 1'b0;
            store_data_q    <= '0;
            rd_out_q        <= '0;
            ctrl_out_q      <= '0;
        end else begin
            // EX/MEM: load a result or a bubble. A bubble clears valid,
            // ctrl and branch_taken; the data fields simply hold.
            if (load_d) begin
                out_valid_q     <= 1'b1;
                alu_result_q    <= res_d;
                zero_q          <= (res_d == '0);
                branch_target_q <= bt_d;
                branch_taken_q  <= ctrl_d[1] && (res_d == '0);
                store_data_q    <= sd_d;
                rd_out_q        <= rd_d;
                ctrl_out_q      <= ctrl_d;
            end else begin
                out_valid_q    <= 1'b0;
                branch_taken_q <= 1'b0;
                ctrl_out_q     <= '0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (accept_mul) begin
                        state_q    <= S_MUL;
                        count_q    <= '0;
                        acc_q      <= '0;
                        mcand_q    <= fwd_a;
                        mplier_q   <= op_b;
                        mul_bt_q   <= bt_new;
                        mul_sd_q   <= fwd_b;
                        mul_rd_q   <= rd;
                        mul_ctrl_q <= ctrl;
                    end
                end
                S_MUL: begin
                    if (flush || count_q == CNT_LAST) begin
                        state_q <= S_IDLE;
                        count_q <= '0;
                    end else begin
                        count_q  <= count_q + CNT_W'(1);
                        acc_q    <= mul_sum;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid     = out_valid_q;
    assign alu_result    = alu_result_q;
    assign zero          = zero_q;
    assign branch_target = branch_target_q;
    assign branch_taken  = branch_taken_q;
    assign store_data    = store_data_q;
    assign rd_out        = rd_out_q;
    assign ctrl_out      = ctrl_out_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// ============================================================================
// tb_ex_stage_pipe
// ----------------------------------------------------------------------------
// Self-checking bench for ex_stage_pipe with default parameters (WIDTH=32).
// Inputs are driven 1 ns after the rising edge and outputs are sampled there
// as well. Expected values come from plain-arithmetic reference functions and
// a small model of the last EX/MEM contents used for forwarding.
// ============================================================================
module tb_ex_stage_pipe;

    localparam int W = 32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] read_data1, read_data2, pc;
    logic [63:0] immediate;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_control;
    logic [7:0]  ctrl;
    logic        flush;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_data;
    logic        stall_out, out_valid, zero, branch_taken;
    logic [31:0] alu_result, branch_target, store_data;
    logic [4:0]  rd_out;
    logic [7:0]  ctrl_out;

    int errors = 0;
    int checks = 0;

    // Model of the EX/MEM register as the bench expects it
    logic        m_valid;
    logic        m_wr;
    logic [4:0]  m_rd;
    logic [31:0] m_res;

    ex_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .read_data1(read_data1), .read_data2(read_data2), .pc(pc),
        .immediate(immediate), .rs1(rs1), .rs2(rs2), .rd(rd),
        .alu_control(alu_control), .ctrl(ctrl), .flush(flush),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
        .stall_out(stall_out), .out_valid(out_valid), .alu_result(alu_result),
        .zero(zero), .branch_target(branch_target), .branch_taken(branch_taken),
        .store_data(store_data), .rd_out(rd_out), .ctrl_out(ctrl_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a, b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a ^ b;
            4'b0110: return a - b;
            4'b0100: return a << b[4:0];
            4'b0101: return a >> b[4:0];
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] rs,
                                            input logic [31:0] rf);
        if (rs == 5'd0) return rf;
        if (m_valid && m_wr && m_rd == rs) return m_res;
        if (wb_regwrite && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; wb_regwrite = 1'b0; wb_rd = 5'd0;
        wb_data = 32'd0; alu_control = 4'b0000; ctrl = 8'h00;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        read_data1 = 32'd0; read_data2 = 32'd0; pc = 32'd0; immediate = 64'd0;
    endtask

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic [4:0] s1, s2, d,
                         input logic [31:0] r1, r2, p,
                         input logic [63:0] im, input logic [7:0] c,
                         input logic fl);
        in_valid = v; alu_control = op; rs1 = s1; rs2 = s2; rd = d;
        read_data1 = r1; read_data2 = r2; pc = p; immediate = im; ctrl = c;
        flush = fl; wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        checks++;
        if ({out_valid, alu_result, zero, branch_target, branch_taken,
             store_data, rd_out, ctrl_out, stall_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%0b res=%h rd=%0d ctrl=%h stall=%0b exp all zero",
                     out_valid, alu_result, rd_out, ctrl_out, stall_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        drive(1'b1, 4'b0010, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 64'd0, 8'h04, 1'b0);
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL add_valid got=%0b exp=1", out_valid);
        end
        checks++;
        if (alu_result !== 32'd12) begin
            errors++; $display("FAIL add_result got=%0d exp=12", alu_result);
        end
        checks++;
        if (rd_out !== 5'd3 || zero !== 1'b0 || store_data !== 32'd7) begin
            errors++; $display("FAIL add_fields got rd=%0d zero=%0b sd=%0d exp rd=3 zero=0 sd=7",
                               rd_out, zero, store_data);
        end
    endtask

    task automatic test_forwarding();
        drive(1'b1, 4'b0010, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 64'd0, 8'h04, 1'b0);
        step();
        drive(1'b1, 4'b0110, 5'd3, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0, 64'd0, 8'h04, 1'b0);
        step();
        checks++;
        if (alu_result !== 32'd0 || zero !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL fwd_sub got res=%h zero=%0b valid=%0b exp res=0 zero=1 valid=1",
                               alu_result, zero, out_valid);
        end
        checks++;
        if (store_data !== 32'd12) begin
            errors++; $display("FAIL fwd_store got=%0d exp=12", store_data);
        end
        drive(1'b1, 4'b0010, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 64'd0, 8'h04, 1'b0);
        step();
        drive(1'b1, 4'b0110, 5'd3, 5'd3, 5'd4, 32'd0, 32'd0, 32'h100, 64'd4, 8'h06, 1'b0);
        step();
        checks++;
        if (branch_taken !== 1'b1 || branch_target !== 32'h108) begin
            errors++; $display("FAIL fwd_branch got taken=%0b target=%h exp taken=1 target=108",
                               branch_taken, branch_target);
        end
    endtask

    task automatic test_rd0();
        drive(1'b1, 4'b0010, 5'd1, 5'd2, 5'd0, 32'd5, 32'd7, 32'd0, 64'd0, 8'h04, 1'b0);
        step();
        drive(1'b1, 4'b0001, 5'd0, 5'd2, 5'd6, 32'h55, 32'd1, 32'd0, 64'd0, 8'h04, 1'b0);
        wb_regwrite = 1'b1; wb_rd = 5'd2; wb_data = 32'd9;
        step();
        checks++;
        if (alu_result !== 32'h5D) begin
            errors++; $display("FAIL rd0_wb_result got=%h exp=5d", alu_result);
        end
        checks++;
        if (store_data !== 32'd9) begin
            errors++; $display("FAIL wb_fwd_store got=%0d exp=9", store_data);
        end
        idle();
    endtask

    task automatic test_mul(input logic [31:0] a, b, input logic [4:0] d);
        logic [31:0] exp;
        int stall_cycles;
        int done_edge;
        exp = ref_alu(4'b1000, a, b);
        stall_cycles = 0;
        done_edge = 0;
        drive(1'b1, 4'b1000, 5'd1, 5'd2, d, a, b, 32'd0, 64'd0, 8'h04, 1'b0);
        for (int cyc = 1; cyc <= 40 && done_edge == 0; cyc++) begin
            #1;
            if (stall_out === 1'b1) stall_cycles++;
            step();
            if (out_valid === 1'b1) done_edge = cyc;
        end
        checks++;
        if (done_edge != W + 1) begin
            errors++; $display("FAIL mul_latency got=%0d exp=%0d (0 = timeout)", done_edge, W + 1);
        end
        checks++;
        if (stall_cycles != W) begin
            errors++; $display("FAIL mul_stall_cycles got=%0d exp=%0d", stall_cycles, W);
        end
        checks++;
        if (alu_result !== exp) begin
            errors++; $display("FAIL mul_result got=%h exp=%h", alu_result, exp);
        end
        checks++;
        if (rd_out !== d || store_data !== b || ctrl_out !== 8'h04) begin
            errors++; $display("FAIL mul_fields got rd=%0d sd=%h ctrl=%h exp rd=%0d sd=%h ctrl=04",
                               rd_out, store_data, ctrl_out, d, b);
        end
        idle();
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL mul_stall_after got=%0b exp=0", stall_out);
        end
    endtask

    task automatic test_reset_mid_mul();
        int stray;
        stray = 0;
        drive(1'b1, 4'b1000, 5'd1, 5'd2, 5'd7, 32'd3, 32'd5, 32'd0, 64'd0, 8'h04, 1'b0);
        repeat (5) step();
        rst = 1'b1;
        idle();
        step();
        step();
        checks++;
        if ({out_valid, alu_result, zero, branch_target, branch_taken,
             store_data, rd_out, ctrl_out, stall_out} !== '0) begin
            errors++; $display("FAIL reset_mid_mul got valid=%0b res=%h stall=%0b exp all zero",
                               out_valid, alu_result, stall_out);
        end
        rst = 1'b0;
        step();
        drive(1'b1, 4'b0010, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 64'd0, 8'h04, 1'b0);
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL reset_idle_stall got=%0b exp=0", stall_out);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'd12) begin
            errors++; $display("FAIL reset_then_add got valid=%0b res=%0d exp valid=1 res=12",
                               out_valid, alu_result);
        end
        idle();
        repeat (40) begin
            step();
            if (out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL reset_stray_result got=%0d valid cycles exp=0", stray);
        end
    endtask

    task automatic test_flush_idle();
        drive(1'b1, 4'b0010, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 64'd0, 8'h04, 1'b1);
        step();
        checks++;
        if (out_valid !== 1'b0 || ctrl_out !== 8'h00) begin
            errors++; $display("FAIL flush_idle got valid=%0b ctrl=%h exp 0 00", out_valid, ctrl_out);
        end
        drive(1'b1, 4'b1000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 64'd0, 8'h04, 1'b1);
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL flush_mul_accept_stall got=%0b exp=0", stall_out);
        end
        step();
        idle();
        #1;
        checks++;
        if (stall_out !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_mul_accept got stall=%0b valid=%0b exp 0 0",
                               stall_out, out_valid);
        end
    endtask

    task automatic test_flush_mul();
        int stray;
        stray = 0;
        drive(1'b1, 4'b1000, 5'd1, 5'd2, 5'd5, 32'd6, 32'd7, 32'd0, 64'd0, 8'h04, 1'b0);
        step();
        repeat (10) step();
        checks++;
        if (stall_out !== 1'b1) begin
            errors++; $display("FAIL flush_pre_stall got=%0b exp=1", stall_out);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL flush_mul_stall got=%0b exp=0", stall_out);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || ctrl_out !== 8'h00) begin
            errors++; $display("FAIL flush_mul_bubble got valid=%0b ctrl=%h exp 0 00", out_valid, ctrl_out);
        end
        drive(1'b1, 4'b0010, 5'd1, 5'd2, 5'd9, 32'd20, 32'd22, 32'd0, 64'd0, 8'h04, 1'b0);
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL flush_then_add_stall got=%0b exp=0", stall_out);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'd42 || rd_out !== 5'd9) begin
            errors++; $display("FAIL flush_then_add got valid=%0b res=%0d rd=%0d exp 1 42 9",
                               out_valid, alu_result, rd_out);
        end
        idle();
        repeat (40) begin
            step();
            if (out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL flush_stray_result got=%0d valid cycles exp=0", stray);
        end
    endtask

    task automatic test_flush_at_done();
        drive(1'b1, 4'b1000, 5'd1, 5'd2, 5'd5, 32'd6, 32'd7, 32'd0, 64'd0, 8'h04, 1'b0);
        step();
        repeat (W - 1) step();
        flush = 1'b1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL done_stall got=%0b exp=0", stall_out);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_wins_done got valid=%0b exp=0", out_valid);
        end
        idle();
        step();
        checks++;
        if (out_valid !== 1'b0 || stall_out !== 1'b0) begin
            errors++; $display("FAIL after_flush_done got valid=%0b stall=%0b exp 0 0", out_valid, stall_out);
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] fa, fb, b, exp_res, exp_bt;
        logic        exp_valid;
        logic [3:0]  op;
        idle();
        step();
        m_valid = 1'b0; m_wr = 1'b0; m_rd = 5'd0; m_res = 32'd0;
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'b1000) op = 4'b0010;
            drive(($urandom_range(0, 7) != 0), op,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom, {$urandom, $urandom},
                  8'($urandom), ($urandom_range(0, 9) == 0));
            wb_regwrite = 1'($urandom);
            wb_rd = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            if ($urandom_range(0, 3) == 0) read_data2 = read_data1;
            fa = ref_fwd(rs1, read_data1);
            fb = ref_fwd(rs2, read_data2);
            b = ctrl[0] ? immediate[31:0] : fb;
            exp_res = ref_alu(op, fa, b);
            exp_bt = pc + immediate[31:0] * 2;
            exp_valid = in_valid && !flush;
            #1;
            checks++;
            if (stall_out !== 1'b0) begin
                errors++; $display("FAIL rnd_stall i=%0d got=%0b exp=0", i, stall_out);
            end
            step();
            checks++;
            if (out_valid !== exp_valid || ctrl_out !== (exp_valid ? ctrl : 8'h00)) begin
                errors++; $display("FAIL rnd_valid i=%0d got valid=%0b ctrl=%h exp valid=%0b ctrl=%h",
                                   i, out_valid, ctrl_out, exp_valid, exp_valid ? ctrl : 8'h00);
            end
            if (exp_valid) begin
                checks++;
                if (alu_result !== exp_res || zero !== (exp_res == 0)) begin
                    errors++; $display("FAIL rnd_result i=%0d op=%b got res=%h zero=%0b exp res=%h zero=%0b",
                                       i, op, alu_result, zero, exp_res, exp_res == 0);
                end
                checks++;
                if (branch_target !== exp_bt || branch_taken !== (ctrl[1] && exp_res == 0) ||
                    store_data !== fb || rd_out !== rd) begin
                    errors++; $display("FAIL rnd_fields i=%0d got bt=%h tk=%0b sd=%h rd=%0d exp bt=%h tk=%0b sd=%h rd=%0d",
                                       i, branch_target, branch_taken, store_data, rd_out,
                                       exp_bt, ctrl[1] && exp_res == 0, fb, rd);
                end
                m_res = exp_res;
                m_rd = rd;
                m_wr = ctrl[2];
            end else begin
                m_wr = 1'b0;
            end
            m_valid = exp_valid;
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_add();
        test_forwarding();
        test_rd0();
        test_mul(32'd6, 32'd7, 5'd5);
        test_reset_mid_mul();
        test_mul(32'hFFFF_FFFF, 32'd2, 5'd8);
        test_mul($urandom, $urandom, 5'd10);
        test_flush_idle();
        test_flush_mul();
        test_flush_at_done();
        test_random(300);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Parametrised execute stage for the pipelined core.
- Contains the ALU, the branch-target adder and the operand-forwarding unit.
- Adds an iterative multi-cycle multiplier with a stall handshake, and a registered EX/MEM pipeline output.
- Sits between the ID/EX register (inputs) and the memory stage (registered outputs).

Parameters:
WIDTH, 32, datapath width (operands, PC, results)
IMM_W, 64, immediate input width; low WIDTH bits used
CTRL_W, 8, control bundle width; bit0=ALUSrc, bit1=Branch, bit2=RegWrite, others pass through

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  ID/EX holds a valid instruction
read_data1  in  WIDTH  rs1 register-file value
read_data2  in  WIDTH  rs2 register-file value
pc  in  WIDTH  instruction PC
immediate  in  IMM_W  sign-extended immediate
rs1, rs2  in  5  source register indices
rd  in  5  destination index
alu_control  in  4  operation code
ctrl  in  CTRL_W  control bundle
flush  in  1  kill current/in-flight instruction
wb_rd  in  5  MEM/WB destination
wb_regwrite  in  1  MEM/WB write enable
wb_data  in  WIDTH  MEM/WB writeback value
stall_out  out  1  upstream must hold ID/EX
out_valid  out  1  EX/MEM holds a valid instruction
alu_result  out  WIDTH  registered result
zero  out  1  registered (alu_result == 0)
branch_target  out  WIDTH  registered pc + (imm << 1)
branch_taken  out  1  registered ctrl[1] & zero-of-result
store_data  out  WIDTH  registered forwarded rs2 value
rd_out  out  5  registered rd
ctrl_out  out  CTRL_W  registered ctrl

Behaviour:
- Reset (synchronous on clk when rst=1): all outputs 0; FSM returns to IDLE; multiplier counter and partial product cleared. Reset overrides flush and any in-flight MUL.
- Forwarding, per source (rs1, rs2):
  - Priority 1, EX/MEM: if out_valid & ctrl_out[2] & rd_out != 0 & rd_out == rsX, use alu_result.
  - Priority 2, MEM/WB: if wb_regwrite & wb_rd != 0 & wb_rd == rsX, use wb_data.
  - Otherwise use read_dataX.
  - Index 0 never forwards.
- Operand B: immediate[WIDTH-1:0] when ctrl[0]=1, else forwarded rs2.
- store_data: always forwarded rs2, never the immediate.
- alu_control codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB.
  - 0100 SLL, 0101 SRL: shift amount is B[log2(WIDTH)-1:0].
  - 0111 SLT: signed compare, result 1 or 0.
  - 1000 MUL: low WIDTH bits of the product, multi-cycle.
  - Any other code: result 0.
- Arithmetic wraps modulo 2^WIDTH; no overflow flag.
- branch_target = pc + (immediate[WIDTH-1:0] << 1), modulo 2^WIDTH.
- FSM states: IDLE, MUL.
- IDLE, single-cycle op: on in_valid & ~flush & op != MUL, EX/MEM loads at the next edge (1-cycle latency) and out_valid=1.
- IDLE, in_valid=0 or flush=1: EX/MEM loads a bubble (out_valid=0, ctrl_out=0); the other fields are don't-care.
- IDLE, MUL accepted (in_valid & op==MUL & ~flush):
  - stall_out=1 combinationally in the accept cycle.
  - Forwarded operands, rd and ctrl are captured internally.
  - Go to MUL with count=0; EX/MEM loads a bubble.
- MUL state:
  - One shift-add step per cycle; count increments.
  - stall_out=1 while count < WIDTH-1.
  - At count == WIDTH-1: stall_out=0, EX/MEM loads the product with out_valid=1, FSM returns to IDLE.
  - Total MUL latency is WIDTH+1 edges from the accept edge.
  - Upstream holds the same instruction through the stall; it is ignored because the FSM is not in IDLE until completion.
- Flush in MUL: abort the multiply, EX/MEM loads a bubble, go to IDLE, stall_out=0 in that cycle.
- Flush in IDLE: the instruction becomes a bubble.
- Simultaneous flush and MUL completion: flush wins and the result is discarded.
- Bubbles never forward, because out_valid=0.
- zero and branch_taken are computed from the value being registered into alu_result.

Test Plan:
- Reset: assert rst for 2 cycles mid-MUL -> all outputs 0, stall_out=0, FSM IDLE on the next cycle.
- ADD x3,x1,x2 with read_data1=5, read_data2=7 -> next cycle alu_result=12, rd_out=3, out_valid=1, zero=0.
- Back-to-back forwarding:
  - ADD x3=12, then SUB x4,x3,x3 with read_data=0 -> alu_result=0, zero=1.
  - Same with ctrl[1]=1, pc=0x100, imm=4 -> branch_taken=1, branch_target=0x108.
- rd=0: forwarding with rd_out=0 and rs1=0 -> register-file value used, no forward. MEM/WB forward: wb_rd=2, wb_data=9, rs2=2 -> 9 used.
- MUL, WIDTH=32: 6 × 7 -> stall_out high for 32 cycles; out_valid=0 (bubbles) during the multiply; alu_result=42 with out_valid=1 on edge 33. Also 0xFFFFFFFF × 2 -> 0xFFFFFFFE.
- Flush: flush at count=10 of a MUL -> next edge out_valid=0, FSM IDLE, stall_out=0; the following ADD completes with normal 1-cycle latency.
